// File: rtl/board_shift_driver.sv
// Serial transmitter for the Connect-4 board: snapshots the cell colours and shifts
// them MSB-first into a 74HC595-style chain, then pulses the storage latch.
module board_shift_driver #(
    parameter int CELLS = 16,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CELLS-1:0] gameboard,
    input  logic [CELLS-1:0] player_cells,
    input  logic             update,
    output logic             sr_data,
    output logic             sr_clk,
    output logic             sr_latch,
    output logic             busy
);

    localparam int FRAME_BITS = 2 * CELLS;
    localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SH_LO = 3'd2,
        ST_SH_HI = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    // Red bit above yellow bit for each cell; owner bits of empty cells are dropped.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [CELLS-1:0] occ,
        input logic [CELLS-1:0] own
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int i = 0; i < CELLS; i++) begin
            f[2*i+1] = occ[i] & ~own[i];
            f[2*i]   = occ[i] &  own[i];
        end
        return f;
    endfunction

    state_t                  state_r, state_n;
    logic [FRAME_BITS-1:0]   shreg_r, shreg_n;
    logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_n;
    logic [DIV_W-1:0]        div_cnt_r, div_cnt_n;
    logic [2*CELLS-1:0]      last_board_r, last_board_n;
    logic                    pending_r, pending_n;
    logic                    sr_data_r, sr_clk_r, sr_latch_r, busy_r;
    logic                    sr_data_n;
    logic [2*CELLS-1:0]      live_s;
    logic                    start_req_s;
    logic                    div_done_s;

    assign live_s      = {gameboard, player_cells & gameboard};
    assign start_req_s = update | (live_s != last_board_r);
    assign div_done_s  = (div_cnt_r == DIV_LAST);

    // Next-state, datapath and pending-request logic.
    always_comb begin
        state_n      = state_r;
        shreg_n      = shreg_r;
        bit_cnt_n    = bit_cnt_r;
        div_cnt_n    = div_cnt_r;
        last_board_n = last_board_r;
        pending_n    = pending_r;
        case (state_r)
            ST_IDLE: begin
                if (start_req_s) begin
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shreg_n      = build_frame(gameboard, player_cells);
                last_board_n = live_s;
                pending_n    = 1'b0;
                bit_cnt_n    = CNT_FULL;
                div_cnt_n    = '0;
                state_n      = ST_SH_LO;
            end
            ST_SH_LO: begin
                if (div_done_s) begin
                    div_cnt_n = '0;
                    state_n   = ST_SH_HI;
                end else begin
                    div_cnt_n = div_cnt_r + DIV_W'(1);
                end
            end
            ST_SH_HI: begin
                if (div_done_s) begin
                    div_cnt_n = '0;
                    shreg_n   = {shreg_r[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_n = bit_cnt_r - CNT_ONE;
                    if (bit_cnt_r == CNT_ONE) begin
                        state_n = ST_LATCH;
                    end else begin
                        state_n = ST_SH_LO;
                    end
                end else begin
                    div_cnt_n = div_cnt_r + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (div_done_s) begin
                    div_cnt_n = '0;
                    // A request landing in the final latch cycle still earns a follow-up frame.
                    if (pending_r || start_req_s) begin
                        state_n = ST_LOAD;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    div_cnt_n = div_cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_n   = ST_IDLE;
                div_cnt_n = '0;
            end
        endcase
        if (start_req_s && (state_r != ST_IDLE) && (state_r != ST_LOAD)) begin
            pending_n = 1'b1;
        end else begin
            pending_n = pending_n;
        end
    end

    // Serial data follows the shifter MSB while shifting and holds across the high phase.
    always_comb begin
        sr_data_n = 1'b0;
        case (state_n)
            ST_SH_LO: sr_data_n = shreg_n[FRAME_BITS-1];
            ST_SH_HI: sr_data_n = sr_data_r;
            default:  sr_data_n = 1'b0;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            shreg_r      <= '0;
            bit_cnt_r    <= '0;
            div_cnt_r    <= '0;
            last_board_r <= '0;
            pending_r    <= 1'b0;
            sr_data_r    <= 1'b0;
            sr_clk_r     <= 1'b0;
            sr_latch_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            shreg_r      <= shreg_n;
            bit_cnt_r    <= bit_cnt_n;
            div_cnt_r    <= div_cnt_n;
            last_board_r <= last_board_n;
            pending_r    <= pending_n;
            sr_data_r    <= sr_data_n;
            sr_clk_r     <= (state_n == ST_SH_HI);
            sr_latch_r   <= (state_n == ST_LATCH);
            busy_r       <= (state_n != ST_IDLE);
        end
    end

    assign sr_data  = sr_data_r;
    assign sr_clk   = sr_clk_r;
    assign sr_latch = sr_latch_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_board_shift_driver.sv
// Directed bench for board_shift_driver: a table of single frames plus hand-written
// sequences for auto-trigger, pending collapse, snapshot stability and mid-frame reset.
module tb_board_shift_driver;

    localparam int CELLS = 16;
    localparam int DIV   = 2;

    logic             clk;
    logic             reset;
    logic [CELLS-1:0] gameboard;
    logic [CELLS-1:0] player_cells;
    logic             update;
    logic             sr_data;
    logic             sr_clk;
    logic             sr_latch;
    logic             busy;

    board_shift_driver #(.CELLS(CELLS), .DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .gameboard    (gameboard),
        .player_cells (player_cells),
        .update       (update),
        .sr_data      (sr_data),
        .sr_clk       (sr_clk),
        .sr_latch     (sr_latch),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Monitor state, cleared through mon_clr so only the monitor writes it.
    logic        mon_clr = 1'b0;
    logic        prev_clk, prev_latch, prev_busy;
    logic [31:0] cap;
    int          edge_cnt, latch_cnt, latch_cyc, busy_cyc, busy_rise, overlap, active_cyc;
    logic [31:0] frames [0:3];
    int          frame_edges [0:3];

    // Sample the serial lines on the falling system-clock edge.
    always @(negedge clk) begin
        if (mon_clr) begin
            cap = 32'h0; edge_cnt = 0; latch_cnt = 0; latch_cyc = 0;
            busy_cyc = 0; busy_rise = 0; overlap = 0; active_cyc = 0;
            for (int k = 0; k < 4; k++) begin
                frames[k] = 32'h0;
                frame_edges[k] = 0;
            end
        end else begin
            if (sr_clk && !prev_clk) begin
                edge_cnt = edge_cnt + 1;
                cap = {cap[30:0], sr_data};
            end
            if (sr_latch) latch_cyc = latch_cyc + 1;
            if (sr_latch && !prev_latch) begin
                if (latch_cnt < 4) begin
                    frames[latch_cnt] = cap;
                    frame_edges[latch_cnt] = edge_cnt;
                end
                latch_cnt = latch_cnt + 1;
                cap = 32'h0;
                edge_cnt = 0;
            end
            if (busy) busy_cyc = busy_cyc + 1;
            if (busy && !prev_busy) busy_rise = busy_rise + 1;
            if (sr_latch && sr_clk) overlap = overlap + 1;
            if (busy || sr_clk || sr_latch) active_cyc = active_cyc + 1;
        end
        prev_clk   = sr_clk;
        prev_latch = sr_latch;
        prev_busy  = busy;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] gb, input logic [15:0] pc);
        @(negedge clk);
        gameboard    = gb;
        player_cells = pc;
        update       = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        logic seen;
        logic done;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        chk(name, {63'h0, done}, 64'h1);
    endtask

    typedef struct {
        logic [15:0] gb;
        logic [15:0] pc;
        logic [31:0] frame;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        vecs[0] = '{16'h0003, 16'h0002, 32'h0000_0006};
        vecs[1] = '{16'hFFFF, 16'h0000, 32'hAAAA_AAAA};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 32'h5555_5555};
        vecs[3] = '{16'h8001, 16'h8000, 32'h4000_0002};
        vecs[4] = '{16'h00F0, 16'h00A0, 32'h0000_6600};
        vecs[5] = '{16'h0000, 16'hFFFF, 32'h0000_0000};

        reset = 1'b0; gameboard = 16'h0; player_cells = 16'h0; update = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {60'h0, sr_data, sr_clk, sr_latch, busy}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Idle with an empty board: nothing may move.
        clear_mon();
        repeat (500) @(negedge clk);
        #1;
        chk("idle_activity", 64'(active_cyc), 64'd0);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            start_frame(vecs[v].gb, vecs[v].pc);
            wait_done(400, $sformatf("vec%0d_timeout", v));
            chk($sformatf("vec%0d_frame", v), 64'(frames[0]), 64'(vecs[v].frame));
            chk($sformatf("vec%0d_edges", v), 64'(frame_edges[0]), 64'd32);
            chk($sformatf("vec%0d_latches", v), 64'(latch_cnt), 64'd1);
            chk($sformatf("vec%0d_latch_len", v), 64'(latch_cyc), 64'(DIV));
            chk($sformatf("vec%0d_busy_len", v), 64'(busy_cyc), 64'd131);
            chk($sformatf("vec%0d_overlap", v), 64'(overlap), 64'd0);
        end

        // Auto-trigger on a board change, no update.
        clear_mon();
        @(negedge clk);
        gameboard = 16'h8000; player_cells = 16'h0000;
        @(negedge clk);
        chk("auto_busy_next", {63'h0, busy}, 64'h1);
        wait_done(400, "auto_timeout");
        chk("auto_frame", 64'(frames[0]), 64'h8000_0000);
        chk("auto_first_bit", {63'h0, frames[0][31]}, 64'h1);
        chk("auto_latches", 64'(latch_cnt), 64'd1);

        // Snapshot stability: board cleared mid-frame.
        clear_mon();
        start_frame(16'hFFFF, 16'h0000);
        repeat (60) @(negedge clk);
        gameboard = 16'h0000; player_cells = 16'h0000;
        wait_done(700, "snap_timeout");
        chk("snap_frame0", 64'(frames[0]), 64'hAAAA_AAAA);
        chk("snap_frame1", 64'(frames[1]), 64'h0);
        chk("snap_edges1", 64'(frame_edges[1]), 64'd32);
        chk("snap_latches", 64'(latch_cnt), 64'd2);

        // Pending collapse: three updates and one board change in one frame.
        clear_mon();
        start_frame(16'h0001, 16'h0000);
        repeat (20) @(negedge clk);
        pulse_update();
        repeat (10) @(negedge clk);
        pulse_update();
        repeat (10) @(negedge clk);
        gameboard = 16'h0003; player_cells = 16'h0003;
        repeat (10) @(negedge clk);
        pulse_update();
        wait_done(700, "pend_timeout");
        chk("pend_latches", 64'(latch_cnt), 64'd2);
        chk("pend_frame0", 64'(frames[0]), 64'h0000_0002);
        chk("pend_frame1", 64'(frames[1]), 64'h0000_0005);
        chk("pend_busy_len", 64'(busy_cyc), 64'd262);
        chk("pend_busy_rise", 64'(busy_rise), 64'd1);

        // Reset at bit 10 aborts the frame without a latch.
        clear_mon();
        start_frame(16'hFFFF, 16'h0000);
        begin
            logic reached;
            reached = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (edge_cnt >= 10) begin
                    reached = 1'b1;
                    break;
                end
            end
            chk("rst_reach_bit10", {63'h0, reached}, 64'h1);
        end
        reset = 1'b0;
        gameboard = 16'h0000; player_cells = 16'h0000;
        #1;
        chk("rst_outputs", {60'h0, sr_data, sr_clk, sr_latch, busy}, 64'h0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_no_latch", 64'(latch_cnt), 64'd0);
        chk("rst_idle_after", {63'h0, busy}, 64'h0);

        clear_mon();
        start_frame(16'h0003, 16'h0002);
        wait_done(400, "post_rst_timeout");
        chk("post_rst_frame", 64'(frames[0]), 64'h0000_0006);
        chk("post_rst_edges", 64'(frame_edges[0]), 64'd32);
        chk("post_rst_busy_len", 64'(busy_cyc), 64'd131);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
